ram_reader: RTL and testbench

- Read-side controller for the logic analyzer's sample RAM. It drives the RAM port in read-only mode.
- After capture completes, it reads a requested number of samples out of the circular sample buffer, newest first, walking addresses downward with wrap-around.
- Each sample is presented to the downstream transmitter over a valid/ready handshake.
- It sits between the sample RAM port and the serial transmit path.

---
 rtl/ram_reader_if.sv | 30 +++
 rtl/ram_reader.sv | 94 +++++++++
 tb/tb_ram_reader.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_reader_if.sv
// Bundles the sample-RAM port, the start/abort controls and the transmit handshake of ram_reader.
// master is the controller side and slave is the RAM/transmitter side.
interface ram_reader_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 5
);
  logic             start_i;
  logic             abort_i;
  logic [DEPTH-1:0] ptr_i;
  logic [DEPTH:0]   cnt_i;
  logic             en_o;
  logic             we_o;
  logic [DEPTH-1:0] addr_o;
  logic [WIDTH-1:0] q_i;
  logic [WIDTH-1:0] data_o;
  logic             valid_o;
  logic             ready_i;
  logic             busy_o;
  logic             done_o;

  modport master (
    input  start_i, abort_i, ptr_i, cnt_i, q_i, ready_i,
    output en_o, we_o, addr_o, data_o, valid_o, busy_o, done_o
  );

  modport slave (
    output start_i, abort_i, ptr_i, cnt_i, q_i, ready_i,
    input  en_o, we_o, addr_o, data_o, valid_o, busy_o, done_o
  );
endinterface

// File: rtl/ram_reader.sv
// Reads the newest samples out of the circular capture RAM, walking addresses downward,
// and hands each one to the transmitter over a valid/ready handshake.
module ram_reader #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 5
) (
  input logic          clk_i,
  input logic          rst_in,
  ram_reader_if.master bus
);

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StWait,
    StSend,
    StDone
  } state_e;

  localparam logic [DEPTH:0]   FullCnt = {1'b1, {DEPTH{1'b0}}};
  localparam logic [DEPTH:0]   RemOne  = 1;
  localparam logic [DEPTH-1:0] AddrOne = 1;

  state_e           state_q, state_d;
  logic [DEPTH-1:0] addr_q, addr_d;
  logic [DEPTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [DEPTH:0]   cnt_clamped;
  logic             en;

  // Counts beyond the buffer size would re-read stale locations, so saturate.
  assign cnt_clamped = (bus.cnt_i > FullCnt) ? FullCnt : bus.cnt_i;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    data_d  = data_q;
    if (bus.abort_i) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.start_i) begin
            addr_d  = bus.ptr_i;
            rem_d   = cnt_clamped;
            state_d = (cnt_clamped == '0) ? StDone : StRead;
          end
        end
        StRead: state_d = StWait;
        StWait: begin
          data_d  = bus.q_i;
          addr_d  = addr_q - AddrOne;
          rem_d   = rem_q - RemOne;
          state_d = StSend;
        end
        StSend: begin
          if (bus.ready_i) begin
            state_d = (rem_q == '0) ? StDone : StRead;
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= StIdle;
      addr_q  <= '0;
      rem_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
    end
  end

  assign en          = (state_q == StRead);
  assign bus.en_o    = en;
  assign bus.we_o    = 1'b0;
  assign bus.addr_o  = en ? addr_q : '0;
  assign bus.data_o  = data_q;
  assign bus.valid_o = (state_q == StSend);
  assign bus.busy_o  = (state_q != StIdle);
  assign bus.done_o  = (state_q == StDone);

  // READ is always followed by WAIT, so the enable can never stay high back to back.
  en_single_cycle: assert property (@(posedge clk_i) disable iff (!rst_in) en |=> !en);

endmodule

// File: tb/tb_ram_reader.sv
// Directed bench for ram_reader: a synchronous RAM model preloaded with 0x100+k and one task
// per scenario checking sample order, timing, clamping, backpressure, abort and reset.
module tb_ram_reader;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 5;

  logic clk_i  = 1'b0;
  logic rst_in = 1'b0;
  always #5 clk_i = ~clk_i;

  ram_reader_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  ram_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_i  (clk_i),
    .rst_in (rst_in),
    .bus    (bus)
  );

  logic [31:0] mem [32];
  always @(posedge clk_i) if (bus.en_o) bus.q_i <= mem[bus.addr_o];

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] got_data [$];
  int          got_cyc  [$];
  logic [4:0]  got_addr [$];
  int first_valid, done_at, done_cnt, en_consec, we_cnt, bp_drop, bp_change, bp_en;
  bit timeout;

  task automatic cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic start_read(input logic [4:0] p, input logic [5:0] n);
    bus.ptr_i   = p;
    bus.cnt_i   = n;
    bus.start_i = 1'b1;
    cycle();
    bus.start_i = 1'b0;
  endtask

  // Observes one readout starting in cycle 1 after the start cycle; stops one cycle past done_o.
  task automatic collect(input int stall, input int inject_at, input int max_cyc);
    int c, stall_left;
    bit prev_en, stall_active, stall_done;
    logic [31:0] snap;
    got_data.delete(); got_cyc.delete(); got_addr.delete();
    first_valid = -1; done_at = -1; done_cnt = 0; en_consec = 0; we_cnt = 0;
    bp_drop = 0; bp_change = 0; bp_en = 0; timeout = 1'b1;
    c = 1; prev_en = 1'b0; stall_left = stall; stall_active = 1'b0; stall_done = (stall == 0);
    snap = '0;
    bus.ready_i = 1'b1;
    while (c <= max_cyc) begin
      bus.start_i = (c == inject_at);
      if (c == inject_at) begin
        bus.ptr_i = 5'd20;
        bus.cnt_i = 6'd3;
      end
      if (bus.en_o) begin
        got_addr.push_back(bus.addr_o);
        if (prev_en) en_consec++;
      end
      prev_en = bus.en_o;
      if (bus.we_o) we_cnt++;
      if (bus.valid_o && first_valid < 0) first_valid = c;
      if (!stall_done && (bus.valid_o || stall_active)) begin
        if (!stall_active) begin
          stall_active = 1'b1;
          snap = bus.data_o;
        end
        if (!bus.valid_o) bp_drop++;
        if (bus.data_o !== snap) bp_change++;
        if (bus.en_o) bp_en++;
        if (stall_left > 0) begin
          bus.ready_i = 1'b0;
          stall_left--;
        end else begin
          bus.ready_i = 1'b1;
          stall_done = 1'b1;
        end
      end else begin
        bus.ready_i = 1'b1;
      end
      if (bus.valid_o && bus.ready_i) begin
        got_data.push_back(bus.data_o);
        got_cyc.push_back(c);
      end
      if (bus.done_o) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
      if (done_at >= 0 && c > done_at) begin
        timeout = 1'b0;
        break;
      end
      cycle();
      c++;
    end
    bus.start_i = 1'b0;
    bus.ready_i = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) cycle();
    n_tests++;
    if ({bus.en_o, bus.we_o, bus.addr_o, bus.data_o, bus.valid_o, bus.busy_o, bus.done_o}
        !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got en=%b we=%b addr=%h data=%h valid=%b busy=%b done=%b expected all 0",
               bus.en_o, bus.we_o, bus.addr_o, bus.data_o, bus.valid_o, bus.busy_o, bus.done_o);
    end
    rst_in = 1'b1;
    cycle();
  endtask

  task automatic test_basic();
    start_read(5'd7, 6'd4);
    collect(0, 0, 60);
    n_tests++;
    if (timeout) begin n_fail++; $display("FAIL basic_timeout: got no done_o expected done_o"); end
    n_tests++;
    if (got_data.size() !== 4) begin
      n_fail++; $display("FAIL basic_count: got %0d samples expected 4", got_data.size());
    end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (got_data[i] !== 32'h107 - i) begin
        n_fail++; $display("FAIL basic_data[%0d]: got %h expected %h", i, got_data[i], 32'h107 - i);
      end
      n_tests++;
      if (got_cyc[i] !== 3 + 3 * i) begin
        n_fail++; $display("FAIL basic_cycle[%0d]: got %0d expected %0d", i, got_cyc[i], 3 + 3 * i);
      end
    end
    n_tests++;
    if (first_valid !== 3) begin
      n_fail++; $display("FAIL basic_latency: got %0d expected 3", first_valid);
    end
    n_tests++;
    if (done_at !== 13 || done_cnt !== 1) begin
      n_fail++; $display("FAIL basic_done: got cycle %0d count %0d expected cycle 13 count 1",
                         done_at, done_cnt);
    end
    n_tests++;
    if (en_consec !== 0 || we_cnt !== 0) begin
      n_fail++; $display("FAIL basic_ram_port: got consec_en=%0d we=%0d expected 0 0",
                         en_consec, we_cnt);
    end
  endtask

  task automatic test_wrap();
    logic [4:0]  exp_addr [4];
    logic [31:0] exp_data [4];
    exp_addr = '{5'd1, 5'd0, 5'd31, 5'd30};
    exp_data = '{32'h101, 32'h100, 32'h11F, 32'h11E};
    start_read(5'd1, 6'd4);
    collect(0, 0, 60);
    n_tests++;
    if (got_data.size() !== 4 || got_addr.size() !== 4 || timeout) begin
      n_fail++; $display("FAIL wrap_count: got %0d data %0d addr timeout=%b expected 4 4 0",
                         got_data.size(), got_addr.size(), timeout);
    end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
        n_fail++; $display("FAIL wrap[%0d]: got addr %0d data %h expected addr %0d data %h",
                           i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
      end
    end
  endtask

  task automatic test_full(input logic [4:0] p, input logic [5:0] n, input string name);
    bit seen [32];
    int distinct, order_err;
    logic [4:0] a;
    start_read(p, n);
    collect(0, 0, 200);
    distinct = 0; order_err = 0;
    for (int i = 0; i < 32; i++) seen[i] = 1'b0;
    for (int i = 0; i < got_addr.size(); i++) begin
      a = p - 5'(i);
      if (!seen[got_addr[i]]) distinct++;
      seen[got_addr[i]] = 1'b1;
      if (got_addr[i] !== a || i >= got_data.size() || got_data[i] !== 32'h100 + 32'(a))
        order_err++;
    end
    n_tests++;
    if (got_addr.size() !== 32 || got_data.size() !== 32 || distinct !== 32) begin
      n_fail++; $display("FAIL %s_count: got %0d addr %0d data %0d distinct expected 32 32 32",
                         name, got_addr.size(), got_data.size(), distinct);
    end
    n_tests++;
    if (order_err !== 0) begin
      n_fail++; $display("FAIL %s_order: got %0d misordered samples expected 0", name, order_err);
    end
    n_tests++;
    if (got_addr.size() == 0 || got_addr[got_addr.size()-1] !== p + 5'd1) begin
      n_fail++; $display("FAIL %s_last_addr: got %0d expected %0d", name,
                         (got_addr.size() == 0) ? -1 : int'(got_addr[got_addr.size()-1]),
                         p + 5'd1);
    end
    n_tests++;
    if (done_at !== 97 || done_cnt !== 1) begin
      n_fail++; $display("FAIL %s_done: got cycle %0d count %0d expected cycle 97 count 1",
                         name, done_at, done_cnt);
    end
  endtask

  task automatic test_backpressure();
    start_read(5'd7, 6'd2);
    collect(10, 0, 80);
    n_tests++;
    if (bp_drop !== 0 || bp_change !== 0 || bp_en !== 0) begin
      n_fail++; $display("FAIL bp_hold: got valid_drops=%0d data_changes=%0d en=%0d expected 0 0 0",
                         bp_drop, bp_change, bp_en);
    end
    n_tests++;
    if (got_data.size() !== 2 || got_data[0] !== 32'h107 || got_data[1] !== 32'h106) begin
      n_fail++; $display("FAIL bp_data: got %0d samples first %h second %h expected 2 107 106",
                         got_data.size(), got_data[0], got_data[1]);
    end
    n_tests++;
    if (got_cyc[0] !== 13 || done_at !== 17) begin
      n_fail++; $display("FAIL bp_timing: got accept %0d done %0d expected 13 17",
                         got_cyc[0], done_at);
    end
  endtask

  task automatic test_zero_and_ignored_start();
    start_read(5'd7, 6'd0);
    collect(0, 0, 20);
    n_tests++;
    if (done_at !== 1 || done_cnt !== 1) begin
      n_fail++; $display("FAIL zero_done: got cycle %0d count %0d expected cycle 1 count 1",
                         done_at, done_cnt);
    end
    n_tests++;
    if (got_addr.size() !== 0 || first_valid !== -1) begin
      n_fail++; $display("FAIL zero_activity: got %0d en pulses first_valid %0d expected 0 -1",
                         got_addr.size(), first_valid);
    end
    start_read(5'd7, 6'd4);
    collect(0, 5, 60);
    n_tests++;
    if (got_data.size() !== 4 || got_data[0] !== 32'h107 || got_data[3] !== 32'h104) begin
      n_fail++; $display("FAIL ignored_start_data: got %0d samples first %h last %h expected 4 107 104",
                         got_data.size(), got_data[0], got_data[3]);
    end
    n_tests++;
    if (done_at !== 13 || done_cnt !== 1) begin
      n_fail++; $display("FAIL ignored_start_done: got cycle %0d count %0d expected 13 1",
                         done_at, done_cnt);
    end
  endtask

  task automatic test_abort();
    int activity;
    start_read(5'd7, 6'd4);
    cycle();
    cycle();
    n_tests++;
    if (bus.valid_o !== 1'b1) begin
      n_fail++; $display("FAIL abort_in_send: got valid %b expected 1", bus.valid_o);
    end
    bus.abort_i = 1'b1;
    bus.start_i = 1'b1;
    bus.ptr_i   = 5'd2;
    bus.cnt_i   = 6'd4;
    bus.ready_i = 1'b1;
    cycle();
    bus.abort_i = 1'b0;
    bus.start_i = 1'b0;
    n_tests++;
    if ({bus.valid_o, bus.busy_o, bus.done_o, bus.en_o} !== 4'b0) begin
      n_fail++; $display("FAIL abort_outputs: got valid=%b busy=%b done=%b en=%b expected 0 0 0 0",
                         bus.valid_o, bus.busy_o, bus.done_o, bus.en_o);
    end
    activity = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.valid_o || bus.busy_o || bus.done_o || bus.en_o) activity++;
      cycle();
    end
    n_tests++;
    if (activity !== 0) begin
      n_fail++; $display("FAIL abort_idle: got %0d active cycles expected 0", activity);
    end
    start_read(5'd1, 6'd2);
    collect(0, 0, 40);
    n_tests++;
    if (got_data.size() !== 2 || got_data[0] !== 32'h101 || got_data[1] !== 32'h100
        || done_cnt !== 1) begin
      n_fail++; $display("FAIL abort_restart: got %0d samples %h %h done %0d expected 2 101 100 1",
                         got_data.size(), got_data[0], got_data[1], done_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int activity;
    start_read(5'd7, 6'd4);
    cycle();
    n_tests++;
    if (bus.busy_o !== 1'b1 || bus.en_o !== 1'b0 || bus.data_o === 32'h0) begin
      n_fail++; $display("FAIL rst_mid_wait: got busy=%b en=%b data=%h expected 1 0 nonzero",
                         bus.busy_o, bus.en_o, bus.data_o);
    end
    rst_in = 1'b0;
    #1;
    n_tests++;
    if ({bus.en_o, bus.we_o, bus.addr_o, bus.data_o, bus.valid_o, bus.busy_o, bus.done_o}
        !== '0) begin
      n_fail++; $display("FAIL rst_mid_outputs: got en=%b addr=%h data=%h valid=%b busy=%b done=%b expected all 0",
                         bus.en_o, bus.addr_o, bus.data_o, bus.valid_o, bus.busy_o, bus.done_o);
    end
    cycle();
    rst_in = 1'b1;
    activity = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (bus.valid_o || bus.done_o || bus.busy_o || bus.en_o) activity++;
    end
    n_tests++;
    if (activity !== 0) begin
      n_fail++; $display("FAIL rst_mid_release: got %0d active cycles expected 0", activity);
    end
  endtask

  initial begin
    for (int k = 0; k < 32; k++) mem[k] = 32'h100 + 32'(k);
    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;
    bus.ptr_i   = '0;
    bus.cnt_i   = '0;
    bus.ready_i = 1'b1;
    test_reset();
    test_basic();
    test_wrap();
    test_full(5'd0, 6'd32, "full");
    test_full(5'd10, 6'd33, "clamp");
    test_backpressure();
    test_zero_and_ignored_start();
    test_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
